// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Decode-stage hazard detection and stall control for a 5-stage pipeline
// (F/D/E/M/W) that uses T_use / T_new forwarding analysis.
//
// Two small trackers shadow the producers in E and M.
//   - The E tracker records the destination register of the instruction now in
//     E and how many more cycles pass before its result can be forwarded (tnew).
//   - The M tracker records the same for the instruction now in M.
// A D-stage source operand stalls when it matches a tracked destination whose
// tnew is larger than the operand's T_use, which means forwarding cannot
// deliver the value in time.
//
// Optional multiply/divide busy tracking is compiled in only when the macro
// STALL_CTRL_MD_EN is defined. Without it md_busy is tied low and the md inputs
// are ignored.
//
// Parameters
//   MULT_CYC   E-stage busy cycles for mult/multu (default 5)
//   DIV_CYC    E-stage busy cycles for div/divu  (default 10)
//
// Ports
//   clk         in   1  sole clock, rising edge
//   reset       in   1  asynchronous, active-low reset
//   rs, rt      in   5  D-stage source register numbers
//   t_use_rs    in   5  T_use of rs (31 = operand not used)
//   t_use_rt    in   5  T_use of rt (31 = operand not used)
//   d_wreg      in   5  D-stage destination register (0 = no write)
//   d_t_new     in   2  cycles from E entry until the D result is forwardable
//   d_is_md     in   1  D holds an instruction that reads or writes HI/LO
//   d_md_start  in   1  D holds mult/multu/div/divu
//   d_md_div    in   1  the start is a divide
//   flush       in   1  synchronous exception/eret flush
//   stall       out  1  freeze F/D and insert a bubble into E
//   if_d_en     out  1  F/D pipeline register enable (~stall)
//   d_e_clr     out  1  D/E pipeline register clear (stall | flush)
//   md_busy     out  1  multiply/divide unit still busy
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] t_use_rs,
    input  logic [4:0] t_use_rt,
    input  logic [4:0] d_wreg,
    input  logic [1:0] d_t_new,
    input  logic       d_is_md,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       flush,
    output logic       stall,
    output logic       if_d_en,
    output logic       d_e_clr,
    output logic       md_busy
);

    // Hazard test for one source operand against both trackers. Register 0 and
    // unused operands (T_use 31) never stall, whatever the trackers hold.
    function automatic logic src_hazard(
        input logic [4:0] src,
        input logic [4:0] t_use,
        input logic [4:0] e_wreg,
        input logic [1:0] e_tnew,
        input logic [4:0] m_wreg,
        input logic [1:0] m_tnew
    );
        logic hit_e;
        logic hit_m;
        hit_e = (src == e_wreg) && ({3'b000, e_tnew} > t_use);
        hit_m = (src == m_wreg) && ({3'b000, m_tnew} > t_use);
        return (src != 5'd0) && (t_use != 5'd31) && (hit_e || hit_m);
    endfunction

    logic [4:0] e_wreg_r;
    logic [1:0] e_tnew_r;
    logic [4:0] m_wreg_r;
    logic [1:0] m_tnew_r;
    logic [1:0] e_tnew_dec_s;
    logic       rs_hazard_s;
    logic       rt_hazard_s;
    logic       md_hazard_s;
    logic       stall_s;

    // Saturating decrement of the E tnew on its way into M.
    always_comb begin
        e_tnew_dec_s = 2'd0;
        if (e_tnew_r != 2'd0) begin
            e_tnew_dec_s = e_tnew_r - 2'd1;
        end else begin
            e_tnew_dec_s = 2'd0;
        end
    end

    // E tracker: takes the D instruction, a bubble on stall, nothing on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_wreg_r <= 5'd0;
            e_tnew_r <= 2'd0;
        end else if (flush) begin
            e_wreg_r <= 5'd0;
            e_tnew_r <= 2'd0;
        end else if (stall_s) begin
            e_wreg_r <= 5'd0;
            e_tnew_r <= 2'd0;
        end else begin
            e_wreg_r <= d_wreg;
            e_tnew_r <= d_t_new;
        end
    end

    // M tracker: always advances from E (stall only freezes F/D), cleared on flush.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_wreg_r <= 5'd0;
            m_tnew_r <= 2'd0;
        end else if (flush) begin
            m_wreg_r <= 5'd0;
            m_tnew_r <= 2'd0;
        end else begin
            m_wreg_r <= e_wreg_r;
            m_tnew_r <= e_tnew_dec_s;
        end
    end

`ifdef STALL_CTRL_MD_EN
    localparam int MD_W = $clog2(DIV_CYC + 2);

    logic [MD_W-1:0] md_cnt_r;

    // Busy counter: loaded by an issuing mult/div, then counts down to zero.
    // A flush does not abort it because the unit keeps working on its operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_cnt_r <= '0;
        end else if (d_md_start && !stall_s && !flush) begin
            if (d_md_div) begin
                md_cnt_r <= MD_W'(DIV_CYC + 1);
            end else begin
                md_cnt_r <= MD_W'(MULT_CYC + 1);
            end
        end else if (md_cnt_r != '0) begin
            md_cnt_r <= md_cnt_r - MD_W'(1);
        end else begin
            md_cnt_r <= md_cnt_r;
        end
    end

    // HI/LO users must wait while the unit is busy.
    always_comb begin
        md_busy     = (md_cnt_r != '0);
        md_hazard_s = d_is_md & md_busy;
    end
`else
    logic        unused_md_s;
    logic [31:0] unused_cfg_s;

    assign unused_md_s  = d_is_md ^ d_md_start ^ d_md_div;
    assign unused_cfg_s = MULT_CYC + DIV_CYC;

    // Multiply/divide tracking compiled out: never busy, never an md hazard.
    always_comb begin
        md_busy     = 1'b0;
        md_hazard_s = 1'b0;
    end
`endif

    // Same-cycle stall decision and pipeline register controls.
    always_comb begin
        rs_hazard_s = src_hazard(rs, t_use_rs, e_wreg_r, e_tnew_r, m_wreg_r, m_tnew_r);
        rt_hazard_s = src_hazard(rt, t_use_rt, e_wreg_r, e_tnew_r, m_wreg_r, m_tnew_r);
        stall_s     = rs_hazard_s | rt_hazard_s | md_hazard_s;
        stall       = stall_s;
        if_d_en     = ~stall_s;
        d_e_clr     = stall_s | flush;
    end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for hazard_stall_ctrl.
// The reference model keeps, per cycle, the instruction that issued from D.
// A consumer stalls when a producer issued one or two cycles earlier still
// needs more cycles than the consumer's T_use. A mult/div keeps the unit busy
// through a fixed cycle number. The expected outputs are queued when a cycle's
// inputs are driven, and a separate monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

`ifdef STALL_CTRL_MD_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif
    localparam int MULT_CYC = 5;
    localparam int DIV_CYC  = 10;
    localparam int MAXC     = 4096;

    logic       clk;
    logic       reset;
    logic [4:0] rs, rt, t_use_rs, t_use_rt, d_wreg;
    logic [1:0] d_t_new;
    logic       d_is_md, d_md_start, d_md_div, flush;
    logic       stall, if_d_en, d_e_clr, md_busy;

    hazard_stall_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rt(rt),
        .t_use_rs(t_use_rs), .t_use_rt(t_use_rt), .d_wreg(d_wreg),
        .d_t_new(d_t_new), .d_is_md(d_is_md), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .flush(flush), .stall(stall),
        .if_d_en(if_d_en), .d_e_clr(d_e_clr), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int stall_seen = 0;
    int cyc = 0;
    int busy_until = -1;
    bit h_valid [MAXC];
    int h_reg   [MAXC];
    int h_tnew  [MAXC];
    logic [3:0] exp_q [$];

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got {stall,if_d_en,d_e_clr,md_busy}=%b expected %b",
                     name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // A producer issued at cycle p is in E at p+1 and M at p+2; it still needs
    // h_tnew[p] - (k-p-1) cycles at cycle k.
    function automatic bit model_hazard(input int src, input int tuse, input int k);
        bit hz = 1'b0;
        for (int j = 1; j <= 2; j++) begin
            int p = k - j;
            if (p >= 0 && src != 0 && tuse != 31 && h_valid[p] && h_reg[p] == src
                && (h_tnew[p] - (j - 1)) > tuse)
                hz = 1'b1;
        end
        return hz;
    endfunction

    function automatic void model_clear();
        if (cyc >= 1) h_valid[cyc-1] = 1'b0;
        if (cyc >= 2) h_valid[cyc-2] = 1'b0;
        busy_until = -1;
    endfunction

    task automatic cyc_drive(input logic rst, input logic [4:0] rs_v, input logic [4:0] rt_v,
                             input logic [4:0] tu_rs, input logic [4:0] tu_rt,
                             input logic [4:0] wreg, input logic [1:0] tnew,
                             input logic is_md, input logic md_start, input logic md_div,
                             input logic fl);
        bit st, busy;
        @(posedge clk);
        #1;
        reset = rst; rs = rs_v; rt = rt_v; t_use_rs = tu_rs; t_use_rt = tu_rt;
        d_wreg = wreg; d_t_new = tnew; d_is_md = is_md; d_md_start = md_start;
        d_md_div = md_div; flush = fl;
        if (!rst) model_clear();
        busy = MD_EN && (cyc <= busy_until);
        st = model_hazard(int'(rs_v), int'(tu_rs), cyc) ||
             model_hazard(int'(rt_v), int'(tu_rt), cyc) || (is_md && busy);
        exp_q.push_back({st, ~st, st | fl, busy});
        h_valid[cyc] = rst && !fl && !st;
        h_reg[cyc]   = int'(wreg);
        h_tnew[cyc]  = int'(tnew);
        if (fl && cyc >= 1) h_valid[cyc-1] = 1'b0;
        if (rst && MD_EN && md_start && !st && !fl)
            busy_until = cyc + (md_div ? DIV_CYC : MULT_CYC) + 1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd8;
            2: return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [4:0] pick_tuse();
        case ($urandom_range(0, 3))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            default: return 5'd31;
        endcase
    endfunction

    // Monitor: compare each cycle's outputs against the queued expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            check("cycle_outputs", {stall, if_d_en, d_e_clr, md_busy}, e);
            if (stall) stall_seen++;
        end
    end

    initial begin
        reset = 1'b0; rs = 5'd0; rt = 5'd0; t_use_rs = 5'd31; t_use_rt = 5'd31;
        d_wreg = 5'd0; d_t_new = 2'd0; d_is_md = 1'b0; d_md_start = 1'b0;
        d_md_div = 1'b0; flush = 1'b0;
        #2;
        check("reset_state", {stall, if_d_en, d_e_clr, md_busy}, 4'b0100);
        for (int i = 0; i < 3; i++)
            cyc_drive(1'b0, 5'd8, 5'd9, 5'd0, 5'd0, 5'd8, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);

        // lw $8 followed by beq on $8: two stall cycles
        settle(); stall_seen = 0;
        cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc_drive(1'b1, 5'd8, 5'd0, 5'd0, 5'd31, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle(); check_int("lw_beq_stall_cycles", stall_seen, 2);

        // addu $9 then sw using $9 late: no stall
        idle(2); settle(); stall_seen = 0;
        cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd9, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc_drive(1'b1, 5'd0, 5'd9, 5'd31, 5'd2, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        settle(); check_int("addu_sw_no_stall", stall_seen, 0);

        // register 0 never stalls, even with a tracked wreg=0, tnew=2
        cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc_drive(1'b1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd10, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // div then mflo, later mult then mflo
        settle(); stall_seen = 0;
        cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 14; i++)
            cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle(); check_int("div_stall_cycles", stall_seen, MD_EN ? DIV_CYC + 1 : 0);
        stall_seen = 0;
        cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++)
            cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle(); check_int("mult_stall_cycles", stall_seen, MD_EN ? MULT_CYC + 1 : 0);
        idle(2);

        // flush while E holds lw $8 and D holds beq on $8
        cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd8, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc_drive(1'b1, 5'd8, 5'd0, 5'd0, 5'd31, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc_drive(1'b1, 5'd8, 5'd0, 5'd0, 5'd31, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(2);

        // asynchronous reset in the middle of a divide (md count at 7)
        cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++)
            cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("pre_async_reset", {stall, if_d_en, d_e_clr, md_busy}, MD_EN ? 4'b1011 : 4'b0100);
        reset = 1'b0;
        #1;
        check("async_reset_mid_div", {stall, if_d_en, d_e_clr, md_busy}, 4'b0100);
        model_clear();
        cyc_drive(1'b0, 5'd0, 5'd0, 5'd31, 5'd31, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle(); stall_seen = 0;
        for (int i = 0; i < 3; i++)
            cyc_drive(1'b1, 5'd0, 5'd0, 5'd31, 5'd31, 5'd2, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle(); check_int("no_busy_after_reset", stall_seen, 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            cyc_drive(($urandom_range(0, 149) != 0), pick_reg(), pick_reg(), pick_tuse(), pick_tuse(),
                      pick_reg(), 2'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0),
                      ($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 19) == 0));
        end
        idle(1);
        settle();
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
